// File: rtl/ring_seq16.sv
// ring_seq16 -- controllable one-hot ring sequencer feeding the 16-to-4 coder.
//
// Optional feature macro: RING_SELF_REPAIR_EN
//   defined   : popcount checker reseeds any non-one-hot state and pulses FAULT
//   undefined : Q rotates whatever it holds, FAULT tied 0
//
// Ports
//   CLK       rising-edge clock
//   RST_N     synchronous reset, active-low
//   EN        advance ring one position
//   DIR       0: hot bit moves i -> i+1, 1: hot bit moves i -> i-1
//   LOAD      load LOAD_PAT verbatim (wins over repair and EN)
//   LOAD_PAT  raw pattern for Q
//   Q         registered ring state
//   WRAP      one-cycle pulse when a step crosses the N-1/0 boundary
//   WRAP_CNT  wrap count modulo 256
//   FAULT     one-cycle pulse when a repair was applied
module ring_seq16 #(
    parameter int N        = 16,
    parameter int SEED_IDX = 0
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         EN,
    input  logic         DIR,
    input  logic         LOAD,
    input  logic [0:N-1] LOAD_PAT,
    output logic [0:N-1] Q,
    output logic         WRAP,
    output logic [0:7]   WRAP_CNT,
    output logic         FAULT
);

    function automatic logic [0:N-1] seed_vec();
        logic [0:N-1] v;
        v           = '0;
        v[SEED_IDX] = 1'b1;
        return v;
    endfunction

    localparam logic [0:N-1] SEED = seed_vec();

    logic [0:N-1] rot_up;   // DIR=0 next state
    logic [0:N-1] rot_dn;   // DIR=1 next state
    logic         wrap_hit; // bit leaving across the boundary for the chosen direction

    // Modulo indexing keeps the rotation correct for any N, including N=1.
    always_comb begin
        rot_up = '0;
        rot_dn = '0;
        for (int i = 0; i < N; i++) begin
            rot_up[(i + 1) % N]     = Q[i];
            rot_dn[(i + N - 1) % N] = Q[i];
        end
        wrap_hit = DIR ? Q[0] : Q[N-1];
    end

`ifdef RING_SELF_REPAIR_EN
    logic onehot;
    logic fault_q;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign onehot = (Q != '0) && ((Q & (Q - 1'b1)) == '0);
    assign FAULT  = fault_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            Q        <= SEED;
            WRAP     <= 1'b0;
            WRAP_CNT <= '0;
            fault_q  <= 1'b0;
        end else begin
            WRAP    <= 1'b0;
            fault_q <= 1'b0;
            if (LOAD) begin
                Q <= LOAD_PAT;
            end else if (!onehot) begin
                Q       <= SEED;
                fault_q <= 1'b1;
            end else if (EN) begin
                Q <= DIR ? rot_dn : rot_up;
                if (wrap_hit) begin
                    WRAP     <= 1'b1;
                    WRAP_CNT <= WRAP_CNT + 8'd1;
                end
            end
        end
    end
`else
    assign FAULT = 1'b0;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            Q        <= SEED;
            WRAP     <= 1'b0;
            WRAP_CNT <= '0;
        end else begin
            WRAP <= 1'b0;
            if (LOAD) begin
                Q <= LOAD_PAT;
            end else if (EN) begin
                Q <= DIR ? rot_dn : rot_up;
                if (wrap_hit) begin
                    WRAP     <= 1'b1;
                    WRAP_CNT <= WRAP_CNT + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ring_seq16.sv
// Directed self-checking bench for ring_seq16 (N=16, SEED_IDX=0).
module tb_ring_seq16;

    localparam int N = 16;

    logic         CLK = 1'b0;
    logic         RST_N, EN, DIR, LOAD;
    logic [0:N-1] LOAD_PAT;
    logic [0:N-1] Q;
    logic         WRAP, FAULT;
    logic [0:7]   WRAP_CNT;

    int checks   = 0;
    int failures = 0;

    ring_seq16 #(.N(N), .SEED_IDX(0)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .DIR(DIR), .LOAD(LOAD),
        .LOAD_PAT(LOAD_PAT), .Q(Q), .WRAP(WRAP), .WRAP_CNT(WRAP_CNT), .FAULT(FAULT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [0:N-1] oh(input int idx);
        logic [0:N-1] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
    endtask

    initial begin
        logic [0:N-1] pat;
        RST_N = 1'b0; EN = 1'b0; DIR = 1'b0; LOAD = 1'b0; LOAD_PAT = '0;

        // Reset state
        do_reset();
        check("rst_q", Q, oh(0));
        check("rst_wrap", WRAP, 0);
        check("rst_cnt", WRAP_CNT, 0);
        check("rst_fault", FAULT, 0);

        // Forward walk over a full revolution
        EN = 1'b1; DIR = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("fwd_q%0d", k), Q, oh(k % 16));
            check($sformatf("fwd_wrap%0d", k), WRAP, (k == 16) ? 1 : 0);
        end
        check("fwd_cnt", WRAP_CNT, 1);

        // Reverse from reset: immediate wrap to bit 15
        do_reset();
        EN = 1'b1; DIR = 1'b1;
        tick();
        check("rev_q1", Q, oh(15));
        check("rev_wrap1", WRAP, 1);
        check("rev_cnt1", WRAP_CNT, 1);
        tick();
        check("rev_q2", Q, oh(14));
        check("rev_wrap2", WRAP, 0);

        // EN toggling
        do_reset();
        DIR = 1'b0;
        EN = 1'b1; tick(); check("tog_q1", Q, oh(1));
        EN = 1'b0; tick(); check("tog_q2", Q, oh(1)); check("tog_w2", WRAP, 0);
        EN = 1'b1; tick(); check("tog_q3", Q, oh(2));
        EN = 1'b0; tick(); check("tog_q4", Q, oh(2));
        check("tog_cnt", WRAP_CNT, 0);

        // LOAD at bit 9 with EN high (EN ignored on load edge), then walk to the wrap
        LOAD = 1'b1; LOAD_PAT = oh(9); EN = 1'b1;
        tick();
        check("ld_q", Q, oh(9));
        check("ld_wrap", WRAP, 0);
        LOAD = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("ld_q15", Q, oh(15));
        check("ld_wrap15", WRAP, 0);
        tick();
        check("ld_q0", Q, oh(0));
        check("ld_wrap0", WRAP, 1);
        check("ld_cnt", WRAP_CNT, 1);

        // Multi-hot and all-zero patterns
        pat = oh(3) | oh(7);
`ifdef RING_SELF_REPAIR_EN
        LOAD = 1'b1; LOAD_PAT = pat; EN = 1'b1;
        tick();
        check("rp_ld_q", Q, pat);
        check("rp_ld_fault", FAULT, 0);
        LOAD = 1'b0;
        tick();
        check("rp_q", Q, oh(0));
        check("rp_fault", FAULT, 1);
        check("rp_wrap", WRAP, 0);
        tick();
        check("rp_fault_clr", FAULT, 0);
        check("rp_step", Q, oh(1));
        LOAD = 1'b1; LOAD_PAT = '0;
        tick();
        check("rz_ld_q", Q, 0);
        LOAD = 1'b0;
        tick();
        check("rz_q", Q, oh(0));
        check("rz_fault", FAULT, 1);
        tick();
        check("rz_fault_clr", FAULT, 0);
`else
        LOAD = 1'b1; LOAD_PAT = pat; EN = 1'b1;
        tick();
        check("mh_ld_q", Q, pat);
        LOAD = 1'b0; DIR = 1'b0;
        tick();
        check("mh_q", Q, oh(4) | oh(8));
        check("mh_fault", FAULT, 0);
        check("mh_wrap", WRAP, 0);
        LOAD = 1'b1; LOAD_PAT = oh(0) | oh(15);
        tick();
        LOAD = 1'b0; DIR = 1'b1;
        tick();
        check("mh_rev_q", Q, oh(15) | oh(14));
        check("mh_rev_wrap", WRAP, 1);
`endif

        // Wrap counter rollover: 256 revolutions
        do_reset();
        EN = 1'b1; DIR = 1'b0;
        for (int k = 0; k < 256 * 16 - 1; k++) tick();
        check("roll_cnt255", WRAP_CNT, 255);
        check("roll_q15", Q, oh(15));
        tick();
        check("roll_cnt0", WRAP_CNT, 0);
        check("roll_q0", Q, oh(0));
        check("roll_wrap", WRAP, 1);

        // Back-to-back wraps by flipping DIR at the boundary
        DIR = 1'b1; tick();
        check("bb_q1", Q, oh(15)); check("bb_w1", WRAP, 1);
        DIR = 1'b0; tick();
        check("bb_q2", Q, oh(0)); check("bb_w2", WRAP, 1);
        check("bb_cnt", WRAP_CNT, 2);

        // Reset wins over EN and LOAD
        RST_N = 1'b0; EN = 1'b1; LOAD = 1'b1; LOAD_PAT = '1;
        tick();
        check("rst2_q", Q, oh(0));
        check("rst2_wrap", WRAP, 0);
        check("rst2_cnt", WRAP_CNT, 0);
        check("rst2_fault", FAULT, 0);
        RST_N = 1'b1; LOAD = 1'b0; EN = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
